// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enable the ring, settle, then count RO rising edges over a CLK window.
// Define RO_MEAS_AVG4_EN to measure four back-to-back windows and report their floor average.
module ro_meas_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             START,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic             RO_IN,
  output logic             RO_EN,
  output logic             BUSY,
  output logic [CNT_W-1:0] DOUT,
  output logic             DOUT_VALID,
  input  logic             DOUT_READY,
  output logic             OVF
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] COUNT  = 2'd2;

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  logic             sync1, sync2, sync3, pulse;
  logic [1:0]       state;
  logic [TMR_W-1:0] tmr, win_m1;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat_hit, ovf_q, fin, accept;
`ifdef RO_MEAS_AVG4_EN
  logic [CNT_W+1:0] acc;
  logic [1:0]       widx;
`endif

  // RO_IN is asynchronous: two-flop synchronizer, third flop for edge detect
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) {sync1, sync2, sync3} <= 3'b000;
    else         {sync1, sync2, sync3} <= {RO_IN, sync1, sync2};
  end
  assign pulse = sync2 & ~sync3;

  // fin covers the result-capture cycle after the window closes; no new run until it is done
  assign accept = (state == IDLE) && START && !DOUT_VALID && !fin;
  assign win_m1 = TMR_W'(win_q) - TMR_W'(1);

  always_comb begin
    cnt_nxt = cnt;
    sat_hit = 1'b0;
    if (state == COUNT && pulse) begin
      if (cnt == '1) sat_hit = 1'b1;
      else           cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      tmr        <= '0;
      win_q      <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
      fin        <= 1'b0;
      RO_EN      <= 1'b0;
      BUSY       <= 1'b0;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
      OVF        <= 1'b0;
`ifdef RO_MEAS_AVG4_EN
      acc        <= '0;
      widx       <= '0;
`endif
    end else begin
      fin <= 1'b0;
      if (DOUT_VALID && DOUT_READY) DOUT_VALID <= 1'b0;
      if (fin) begin
`ifdef RO_MEAS_AVG4_EN
        DOUT <= acc[CNT_W+1:2];
`else
        DOUT <= cnt;
`endif
        OVF        <= ovf_q;
        DOUT_VALID <= 1'b1;
        BUSY       <= 1'b0;
      end
      case (state)
        IDLE: if (accept) begin
          state <= SETTLE;
          tmr   <= SETTLE_LD;
          win_q <= (WINDOW == '0) ? WIN_W'(1) : WINDOW;
          cnt   <= '0;
          ovf_q <= 1'b0;
          OVF   <= 1'b0;
          RO_EN <= 1'b1;
          BUSY  <= 1'b1;
`ifdef RO_MEAS_AVG4_EN
          acc   <= '0;
          widx  <= '0;
`endif
        end
        SETTLE: begin
          if (tmr == '0) begin
            state <= COUNT;
            tmr   <= win_m1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        COUNT: begin
          cnt <= cnt_nxt;
          if (sat_hit) ovf_q <= 1'b1;
          if (tmr != '0) begin
            tmr <= tmr - TMR_W'(1);
          end else begin
`ifdef RO_MEAS_AVG4_EN
            acc <= acc + (CNT_W+2)'(cnt_nxt);
            if (widx != 2'd3) begin
              widx <= widx + 2'd1;
              tmr  <= win_m1;
              cnt  <= '0;
            end else begin
              state <= IDLE;
              RO_EN <= 1'b0;
              fin   <= 1'b1;
            end
`else
            state <= IDLE;
            RO_EN <= 1'b0;
            fin   <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
